core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle fetch/decode/execute/writeback controller for `core`. It fetches instruction words from instruction memory over a req/ack handshake and presents each one to the core's `instr` input. It holds the word stable while the core's combinational datapath settles, strobes the register file, and computes the next program counter. It sits between instruction memory, the register file and `core`, and is the only block that advances the PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `EXEC_CYCLES`, 2: settle cycles spent in EXEC; legal range 1..15.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-low. `rst`=0 at a rising edge resets the block.
- `run` in 1: level. 1 = keep issuing instructions.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address (word address, equals `pc`).
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: latched instruction driven to `core.instr`.
- `core_pc` in 32: `core.programCounter`; sampled in the last EXEC cycle.
- `rf_re` out 1: register-file read enable; high during DECODE and EXEC.
- `rf_we` out 1: register-file write strobe; one-cycle pulse in WB.
- `pc` out 32: current program counter.
- `state` out 3: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky illegal-opcode flag (see Configuration).
- `retired` out 32: count of completed instructions.

## Operation
- Reset values: `pc`=RESET_PC, `instr`=0, `imem_req`=0, `imem_addr`=RESET_PC, `rf_re`=0, `rf_we`=0, `state`=IDLE, `halted`=0, `illegal`=0, `retired`=0, EXEC counter=0.
- IDLE: if `run`=1, go to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`. On ack, latch `imem_rdata` into `instr` and go to DECODE. No timeout.
- DECODE: one cycle. `rf_re`=1. The opcode `instr[31:24]` is classified:
  - ALU: 0x05–0x0A, 0x45–0x4C (includes 0x48/0x49 shifts). Write-back.
  - STORE: 0x83. Write-back.
  - JUMP: 0x01 JP, 0x02 JAL. No write-back.
  - BRANCH: 0x41–0x44. No write-back.
  - LOAD: 0x81, 0x82. No write-back.
  - HALT: 0xFF.
  - Anything else is ILLEGAL.
- EXEC: `rf_re`=1 for EXEC_CYCLES cycles. HALT goes directly from DECODE to HALT and skips EXEC.
- WB: one cycle.
  - `rf_we`=1 only for ALU/STORE.
  - `retired` increments by 1.
  - PC update:
    - JUMP: `pc` ← {8'h00, `instr[23:0]`}.
    - BRANCH: `pc` ← `core_pc` if `core_pc` ≠ `pc`, else `pc`+1. A branch whose target equals the current PC falls through.
    - All others: `pc` ← `pc`+1.
  - Next state is FETCH if `run`=1, else IDLE.
- HALT: absorbing; `halted`=1; `run` is ignored; only reset exits.
- `run` dropped mid-instruction: the current instruction completes through WB, then IDLE.
- Wrap-around: `pc` 32'hFFFF_FFFF+1 → 0; `retired` 32'hFFFF_FFFF+1 → 0.
- Reset mid-operation, including during FETCH without ack: all outputs return to reset values at that edge; the pending fetch is abandoned.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Zero-wait ack (ack in first FETCH cycle): FETCH→FETCH period is 3+EXEC_CYCLES cycles (5 at default).
- Each ack wait cycle adds one cycle.
- `instr` changes only at the FETCH→DECODE edge.
- `pc` changes only at the WB exit edge.
- `core_pc` must be valid in the final EXEC cycle.
- `rf_we` is never high in two consecutive cycles.
- `imem_ack` outside FETCH is ignored.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined: an ILLEGAL opcode sets `illegal`=1 and goes DECODE→HALT. `retired` and `pc` are unchanged.
- Not defined: ILLEGAL executes as a NOP through EXEC/WB with `rf_we`=0, `pc`+1, `retired`+1. `illegal` is tied to 0.

## Test plan
- ADD: reset, `run`=1, zero-wait ack, `imem_rdata`=32'h0803_0102 at pc 0 → `rf_we` high exactly one cycle, `pc`=1, `retired`=1, next FETCH 5 cycles after the first.
- JP: `imem_rdata`=32'h0100_0010 → `pc`=32'h10, `rf_we` stays 0.
- BEQI taken/not taken at `pc`=4 (32'h4305_0020):
  - `core_pc`=32'h20 → `pc`=32'h20.
  - `core_pc`=4 → `pc`=5.
- Delayed ack and reset: ack delayed 3 cycles → `imem_req`=1 and `imem_addr` stable for 4 cycles. Separately, `rst`=0 during the wait → `imem_req`=0, `state`=0, `pc`=RESET_PC after that edge.
- Illegal and stop: `run` dropped during EXEC → instruction retires, `state`=IDLE. Opcode 8'h00:
  - Macro defined → `halted`=1, `illegal`=1, `retired` unchanged.
  - Macro undefined → `pc`+1, no `rf_we`.
- HALT: 32'hFF00_0000 → `state`=5, `halted`=1; toggling `run` for 10 cycles produces no `imem_req`.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/writeback controller.
// Optional: define SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT.

module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [31:0] core_pc,
  output logic        rf_re,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_STORE,
    C_JUMP,
    C_BRANCH,
    C_LOAD,
    C_HALT,
    C_ILL
  } cls_t;

  localparam logic [3:0] LP_LAST = 4'(EXEC_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_n;
  logic        r_req;
  logic        r_re;
  logic        r_we;
  logic        r_halted;
  logic        r_illegal;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_core_pc;
  logic [31:0] r_retired;

  logic [7:0]  w_op;
  cls_t        w_cls;
  logic        w_wb_en;
  logic        w_trap;
  logic [31:0] w_pc_inc;
  logic [31:0] w_pc_nxt;

  assign w_op = r_instr[31:24];

  // Classify the latched opcode.
  always_comb begin
    w_cls = C_ILL;
    unique case (1'b1)
      (w_op >= 8'h05 && w_op <= 8'h0A): w_cls = C_ALU;
      (w_op >= 8'h45 && w_op <= 8'h4C): w_cls = C_ALU;
      (w_op == 8'h83):                  w_cls = C_STORE;
      (w_op == 8'h01 || w_op == 8'h02): w_cls = C_JUMP;
      (w_op >= 8'h41 && w_op <= 8'h44): w_cls = C_BRANCH;
      (w_op == 8'h81 || w_op == 8'h82): w_cls = C_LOAD;
      (w_op == 8'hFF):                  w_cls = C_HALT;
      default:                          w_cls = C_ILL;
    endcase
  end

  assign w_wb_en  = (w_cls == C_ALU) || (w_cls == C_STORE);
  assign w_pc_inc = r_pc + 32'd1;

  // Next PC; a branch to its own address falls through.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (w_cls)
      C_JUMP:   w_pc_nxt = {8'h00, r_instr[23:0]};
      C_BRANCH: w_pc_nxt = (r_core_pc != r_pc) ? r_core_pc : w_pc_inc;
      default:  w_pc_nxt = w_pc_inc;
    endcase
  end

  // Next-state and EXEC counter logic.
  always_comb begin
    w_next  = r_state;
    w_cnt_n = r_cnt;
    w_trap  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next  = S_EXEC;
        w_cnt_n = 4'd0;
        if (w_cls == C_HALT) w_next = S_HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
        if (w_cls == C_ILL) begin
          w_next = S_HALT;
          w_trap = 1'b1;
        end
`endif
      end
      S_EXEC: begin
        if (r_cnt == LP_LAST) begin
          w_next  = S_WB;
          w_cnt_n = 4'd0;
        end else begin
          w_cnt_n = r_cnt + 4'd1;
        end
      end
      S_WB: begin
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_req     <= 1'b0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_n;
      r_req    <= (w_next == S_FETCH);
      r_re     <= (w_next == S_DECODE) || (w_next == S_EXEC);
      r_we     <= (w_next == S_WB) && w_wb_en;
      r_halted <= (w_next == S_HALT);
      if (w_trap) r_illegal <= 1'b1;
    end
  end

  // Instruction latch and core PC sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instr   <= 32'd0;
      r_core_pc <= 32'd0;
    end else begin
      if (r_state == S_FETCH && imem_ack) r_instr <= imem_rdata;
      if (r_state == S_EXEC && r_cnt == LP_LAST) r_core_pc <= core_pc;
    end
  end

  // PC and retire counter advance only on WB exit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_retired <= 32'd0;
    end else if (r_state == S_WB) begin
      r_pc      <= w_pc_nxt;
      r_retired <= r_retired + 32'd1;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign rf_re     = r_re;
  assign rf_we     = r_we;
  assign pc        = r_pc;
  assign state     = r_state;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign retired   = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized self-checking bench for core_sequencer.
// Expectations come from an instruction-level model of PC/retire behaviour.

module tb_core_sequencer;

  localparam int EXEC = 2;
`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] core_pc;
  logic        rf_re;
  logic        rf_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  bit          m_ill;
  bit          m_halt;

  core_sequencer #(.RESET_PC(32'h0), .EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .core_pc(core_pc),
    .rf_re(rf_re), .rf_we(rf_we), .pc(pc), .state(state),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // 0 ALU, 1 STORE, 2 JUMP, 3 BRANCH, 4 LOAD, 5 HALT, 6 ILLEGAL
  function automatic int cls_of(input logic [7:0] op);
    if (op inside {[8'h05:8'h0A], [8'h45:8'h4C]}) return 0;
    if (op == 8'h83) return 1;
    if (op inside {8'h01, 8'h02}) return 2;
    if (op inside {[8'h41:8'h44]}) return 3;
    if (op inside {8'h81, 8'h82}) return 4;
    if (op == 8'hFF) return 5;
    return 6;
  endfunction

  function automatic bit is_trap(input logic [31:0] w);
    int c;
    c = cls_of(w[31:24]);
    return (c == 5) || (c == 6 && TRAP);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ret = 32'h0; m_ill = 0; m_halt = 0;
  endtask

  task automatic model_apply(input logic [31:0] w, input logic [31:0] cpc,
                             input bit run_after, output int e_nwe,
                             output logic [2:0] e_state);
    int c;
    c = cls_of(w[31:24]);
    e_nwe = 0;
    if (is_trap(w)) begin
      m_halt = 1;
      if (c == 6) m_ill = 1;
      e_state = 3'd5;
    end else begin
      if (c <= 1) e_nwe = 1;
      if (c == 2) m_pc = {8'h00, w[23:0]};
      else if (c == 3 && cpc != m_pc) m_pc = cpc;
      else m_pc = m_pc + 1;
      m_ret = m_ret + 1;
      e_state = run_after ? 3'd1 : 3'd0;
    end
  endtask

  task automatic run_one(input logic [31:0] word, input int delay,
                         input logic [31:0] cpc, input bit drop_run,
                         output int o_nreq, output bit o_addr_ok,
                         output int o_period, output int o_nwe,
                         output int o_nre, output bit o_consec,
                         output bit o_pc_early, output bit o_tmo);
    int g;
    logic [31:0] a0, p0;
    bit prev_we;
    o_nreq = 0; o_addr_ok = 1; o_period = 0; o_nwe = 0; o_nre = 0;
    o_consec = 0; o_pc_early = 0; o_tmo = 0;
    g = 0;
    while (imem_req !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (imem_req !== 1'b1) begin
      o_tmo = 1;
      return;
    end
    a0 = imem_addr;
    p0 = pc;
    for (int k = 0; k <= delay; k++) begin
      if (imem_req === 1'b1) o_nreq++;
      if (imem_addr !== a0) o_addr_ok = 0;
      imem_ack = (k == delay);
      imem_rdata = (k == delay) ? word : $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    core_pc = cpc;
    prev_we = 0;
    o_period = delay + 1;
    g = 0;
    while (g < 40) begin
      if (state == 3'd1 || state == 3'd0 || state == 3'd5) break;
      if (rf_we === 1'b1) o_nwe++;
      if (rf_we === 1'b1 && prev_we) o_consec = 1;
      prev_we = (rf_we === 1'b1);
      if (rf_re === 1'b1) o_nre++;
      if (pc !== p0) o_pc_early = 1;
      if (drop_run && g == 1) run = 1'b0;
      g++;
      o_period++;
      @(negedge clk);
    end
    if (g >= 40) o_tmo = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h exp 0", pc); end
    n_checks++; if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h exp 0", imem_addr); end
    n_checks++; if (rf_re !== 1'b0 || rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_rf: got re=%b we=%b exp 0/0", rf_re, rf_we); end
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    n_checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got h=%b i=%b exp 0/0", halted, illegal); end
    n_checks++; if (retired !== 32'h0) begin n_errors++; $display("FAIL reset_retired: got %h exp 0", retired); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== 3'd0 || imem_req !== 1'b0) begin n_errors++; $display("FAIL idle_hold: got state=%0d req=%b exp 0/0", state, imem_req); end
  endtask

  task automatic test_add();
    int nreq, per, nwe, nre, e_nwe;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    run = 1'b1;
    run_one(32'h0803_0102, 0, $urandom, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h0803_0102, 32'h0, 1, e_nwe, e_st);
    n_checks++; if (tmo) begin n_errors++; $display("FAIL add_timeout: got 1 exp 0"); end
    n_checks++; if (nwe != 1 || cons) begin n_errors++; $display("FAIL add_we: got %0d cons=%b exp 1", nwe, cons); end
    n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL add_pc: got %h exp %h", pc, m_pc); end
    n_checks++; if (retired !== m_ret) begin n_errors++; $display("FAIL add_retired: got %h exp %h", retired, m_ret); end
    n_checks++; if (per != 3 + EXEC) begin n_errors++; $display("FAIL add_period: got %0d exp %0d", per, 3 + EXEC); end
    n_checks++; if (instr !== 32'h0803_0102) begin n_errors++; $display("FAIL add_instr: got %h exp 08030102", instr); end
    n_checks++; if (nre != EXEC + 1) begin n_errors++; $display("FAIL add_re: got %0d exp %0d", nre, EXEC + 1); end
  endtask

  task automatic test_jump();
    int nreq, per, nwe, nre, e_nwe;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    run_one(32'h0100_0010, 0, $urandom, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h0100_0010, 32'h0, 1, e_nwe, e_st);
    n_checks++; if (pc !== 32'h10) begin n_errors++; $display("FAIL jp_pc: got %h exp 10", pc); end
    n_checks++; if (nwe != 0) begin n_errors++; $display("FAIL jp_we: got %0d exp 0", nwe); end
    n_checks++; if (early) begin n_errors++; $display("FAIL jp_pc_early: got 1 exp 0"); end
  endtask

  task automatic test_branch();
    int nreq, per, nwe, nre, e_nwe;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    run_one(32'h0100_0004, 0, 32'h0, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h0100_0004, 32'h0, 1, e_nwe, e_st);
    run_one(32'h4305_0020, 0, 32'h20, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h4305_0020, 32'h20, 1, e_nwe, e_st);
    n_checks++; if (pc !== 32'h20) begin n_errors++; $display("FAIL beq_taken_pc: got %h exp 20", pc); end
    n_checks++; if (nwe != 0) begin n_errors++; $display("FAIL beq_we: got %0d exp 0", nwe); end
    run_one(32'h0100_0004, 1, 32'h0, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h0100_0004, 32'h0, 1, e_nwe, e_st);
    run_one(32'h4305_0020, 0, 32'h4, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h4305_0020, 32'h4, 1, e_nwe, e_st);
    n_checks++; if (pc !== 32'h5) begin n_errors++; $display("FAIL beq_fall_pc: got %h exp 5", pc); end
  endtask

  task automatic test_wrap();
    int nreq, per, nwe, nre, e_nwe;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    run_one(32'h4100_0000, 0, 32'hFFFF_FFFF, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h4100_0000, 32'hFFFF_FFFF, 1, e_nwe, e_st);
    n_checks++; if (pc !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap_pre_pc: got %h exp ffffffff", pc); end
    run_one(32'h4500_0000, 0, 32'h0, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h4500_0000, 32'h0, 1, e_nwe, e_st);
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL wrap_pc: got %h exp 0", pc); end
  endtask

  task automatic test_delayed_ack();
    int nreq, per, nwe, nre, e_nwe;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    run_one(32'h0A00_0000, 3, 32'h0, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h0A00_0000, 32'h0, 1, e_nwe, e_st);
    n_checks++; if (nreq != 4 || !aok) begin n_errors++; $display("FAIL dly_req: got %0d cycles stable=%b exp 4/1", nreq, aok); end
    n_checks++; if (per != 6 + EXEC) begin n_errors++; $display("FAIL dly_period: got %0d exp %0d", per, 6 + EXEC); end
    n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL dly_pc: got %h exp %h", pc, m_pc); end
  endtask

  task automatic test_reset_mid_fetch();
    int g;
    g = 0;
    while (imem_req !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL rstf_fetch: got req=%b exp 1", imem_req); end
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    n_checks++; if (imem_req !== 1'b0 || state !== 3'd0) begin n_errors++; $display("FAIL rstf_ctl: got req=%b state=%0d exp 0/0", imem_req, state); end
    n_checks++; if (pc !== 32'h0 || retired !== 32'h0 || instr !== 32'h0) begin n_errors++; $display("FAIL rstf_regs: got pc=%h ret=%h instr=%h exp 0", pc, retired, instr); end
    rst = 1'b1;
  endtask

  task automatic test_run_drop();
    int nreq, per, nwe, nre, e_nwe;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    run = 1'b1;
    run_one(32'h8300_0000, $urandom_range(0, 2), 32'h0, 1, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h8300_0000, 32'h0, 0, e_nwe, e_st);
    n_checks++; if (state !== e_st) begin n_errors++; $display("FAIL drop_state: got %0d exp %0d", state, e_st); end
    n_checks++; if (retired !== m_ret || pc !== m_pc) begin n_errors++; $display("FAIL drop_retire: got ret=%h pc=%h exp %h/%h", retired, pc, m_ret, m_pc); end
    n_checks++; if (nwe != e_nwe) begin n_errors++; $display("FAIL drop_we: got %0d exp %0d", nwe, e_nwe); end
    repeat (3) @(negedge clk);
    n_checks++; if (state !== 3'd0 || imem_req !== 1'b0) begin n_errors++; $display("FAIL drop_idle: got state=%0d req=%b exp 0/0", state, imem_req); end
    run = 1'b1;
  endtask

  task automatic test_random();
    int nreq, per, nwe, nre, e_nwe, sel, dly, x;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    logic [7:0] op;
    logic [31:0] w, cpc, tmp;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: begin
          x = $urandom_range(0, 13);
          op = (x < 6) ? 8'(8'h05 + x) : 8'(8'h45 + x - 6);
        end
        1: op = 8'h83;
        2: op = 8'(8'h01 + $urandom_range(0, 1));
        3: op = 8'(8'h41 + $urandom_range(0, 3));
        4: op = 8'(8'h81 + $urandom_range(0, 1));
        default: begin
          op = 8'h07;
          if (!TRAP) begin
            op = 8'($urandom);
            while (cls_of(op) != 6) op = 8'($urandom);
          end
        end
      endcase
      tmp = $urandom;
      w = {op, tmp[23:0]};
      cpc = ($urandom_range(0, 3) == 0) ? m_pc : $urandom;
      dly = $urandom_range(0, 3);
      run_one(w, dly, cpc, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
      model_apply(w, cpc, 1, e_nwe, e_st);
      n_checks++; if (tmo) begin n_errors++; $display("FAIL rnd_timeout[%0d]: got 1 exp 0", i); end
      n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc[%0d] w=%h: got %h exp %h", i, w, pc, m_pc); end
      n_checks++; if (retired !== m_ret) begin n_errors++; $display("FAIL rnd_retired[%0d]: got %h exp %h", i, retired, m_ret); end
      n_checks++; if (nwe != e_nwe || cons) begin n_errors++; $display("FAIL rnd_we[%0d] w=%h: got %0d exp %0d", i, w, nwe, e_nwe); end
      n_checks++; if (per != dly + 3 + EXEC) begin n_errors++; $display("FAIL rnd_period[%0d]: got %0d exp %0d", i, per, dly + 3 + EXEC); end
      n_checks++; if (state !== e_st) begin n_errors++; $display("FAIL rnd_state[%0d]: got %0d exp %0d", i, state, e_st); end
      n_checks++; if (early || nre != EXEC + 1 || nreq != dly + 1) begin n_errors++; $display("FAIL rnd_timing[%0d]: got early=%b re=%0d req=%0d exp 0/%0d/%0d", i, early, nre, nreq, EXEC + 1, dly + 1); end
      n_checks++; if (instr !== w) begin n_errors++; $display("FAIL rnd_instr[%0d]: got %h exp %h", i, instr, w); end
      n_checks++; if (illegal !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("FAIL rnd_flags[%0d]: got i=%b h=%b exp 0/0", i, illegal, halted); end
    end
  endtask

  task automatic test_illegal();
    int nreq, per, nwe, nre, e_nwe;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    logic [31:0] w, tmp;
    tmp = $urandom;
    w = {8'h00, tmp[23:0]};
    run = 1'b1;
    run_one(w, $urandom_range(0, 2), $urandom, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(w, 32'h0, 1, e_nwe, e_st);
    n_checks++; if (state !== e_st) begin n_errors++; $display("FAIL ill_state: got %0d exp %0d", state, e_st); end
    n_checks++; if (illegal !== m_ill || halted !== m_halt) begin n_errors++; $display("FAIL ill_flags: got i=%b h=%b exp %b/%b", illegal, halted, m_ill, m_halt); end
    n_checks++; if (pc !== m_pc || retired !== m_ret) begin n_errors++; $display("FAIL ill_regs: got pc=%h ret=%h exp %h/%h", pc, retired, m_pc, m_ret); end
    n_checks++; if (nwe != 0) begin n_errors++; $display("FAIL ill_we: got %0d exp 0", nwe); end
  endtask

  task automatic test_halt();
    int nreq, per, nwe, nre, e_nwe, reqs, moved;
    bit aok, cons, early, tmo;
    logic [2:0] e_st;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run = 1'b1;
    run_one(32'h0100_0033, 0, 32'h0, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'h0100_0033, 32'h0, 1, e_nwe, e_st);
    run_one(32'hFF00_0000, 0, 32'h0, 0, nreq, aok, per, nwe, nre, cons, early, tmo);
    model_apply(32'hFF00_0000, 32'h0, 1, e_nwe, e_st);
    n_checks++; if (state !== 3'd5 || halted !== 1'b1) begin n_errors++; $display("FAIL halt_state: got %0d h=%b exp 5/1", state, halted); end
    n_checks++; if (pc !== m_pc || retired !== m_ret) begin n_errors++; $display("FAIL halt_regs: got pc=%h ret=%h exp %h/%h", pc, retired, m_pc, m_ret); end
    n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL halt_ill: got %b exp 0", illegal); end
    reqs = 0; moved = 0;
    for (int i = 0; i < 10; i++) begin
      run = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (imem_req !== 1'b0) reqs++;
      if (state !== 3'd5 || rf_re !== 1'b0) moved++;
    end
    imem_ack = 1'b0;
    n_checks++; if (reqs != 0) begin n_errors++; $display("FAIL halt_req: got %0d exp 0", reqs); end
    n_checks++; if (moved != 0) begin n_errors++; $display("FAIL halt_absorb: got %0d exp 0", moved); end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0;
    imem_rdata = 32'h0; core_pc = 32'h0;
    test_reset();
    test_add();
    test_jump();
    test_branch();
    test_wrap();
    test_delayed_ack();
    test_reset_mid_fetch();
    test_run_drop();
    test_random();
    test_illegal();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
